// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, loads IF/ID,
// and applies stall/redirect requests with halt detection and fetch trapping.
module fetch_controller #(
  parameter logic [31:0] ROM_LAST_ADDR = 32'd400,
  parameter logic [31:0] HALT_WORD     = 32'hA800FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] rom_instruction,
  output logic [31:0] rom_address,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instr_next, pc_plus4_next;
  logic        valid_next;
  logic [15:0] fetch_count_next, flush_count_next;

  // Widened to 33 bits so an address near 2^32 cannot wrap past the range check.
  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (({1'b0, addr} + 33'd3) <= {1'b0, ROM_LAST_ADDR});
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // NOTE: every always_comb output gets a hold/default value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instr_next       = if_id_instruction;
    pc_plus4_next    = if_id_pc_plus4;
    valid_next       = if_id_valid;
    fetch_count_next = fetch_count;
    flush_count_next = flush_count;

    case (state)
      RUN, HALT: begin
        if (branch_taken) begin
          instr_next       = 32'd0;
          pc_plus4_next    = 32'd0;
          valid_next       = 1'b0;
          flush_count_next = sat_inc(flush_count);
          if (is_legal(branch_target)) begin
            pc_next    = branch_target;
            state_next = RUN;
          end else begin
            state_next = FAULT;
          end
        end else if (stall) begin
          // Everything holds; defaults already cover it.
        end else if (state == HALT) begin
          instr_next    = 32'd0;
          pc_plus4_next = 32'd0;
          valid_next    = 1'b0;
        end else if (!is_legal(pc)) begin
          instr_next    = 32'd0;
          pc_plus4_next = 32'd0;
          valid_next    = 1'b0;
          state_next    = FAULT;
        end else begin
          instr_next       = rom_instruction;
          pc_plus4_next    = pc + 32'd4;
          valid_next       = 1'b1;
          fetch_count_next = sat_inc(fetch_count);
          if (rom_instruction == HALT_WORD) begin
            state_next = HALT;
          end else begin
            pc_next = pc + 32'd4;
          end
        end
      end
      FAULT: begin
        instr_next    = 32'd0;
        pc_plus4_next = 32'd0;
        valid_next    = 1'b0;
      end
      default: begin
        state_next    = FAULT;
        instr_next    = 32'd0;
        pc_plus4_next = 32'd0;
        valid_next    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= RUN;
      pc                <= 32'd0;
      if_id_instruction <= 32'd0;
      if_id_pc_plus4    <= 32'd0;
      if_id_valid       <= 1'b0;
      fetch_count       <= 16'd0;
      flush_count       <= 16'd0;
    end else begin
      state             <= state_next;
      pc                <= pc_next;
      if_id_instruction <= instr_next;
      if_id_pc_plus4    <= pc_plus4_next;
      if_id_valid       <= valid_next;
      fetch_count       <= fetch_count_next;
      flush_count       <= flush_count_next;
    end
  end

  assign rom_address = pc;
  assign halted      = (state == HALT);
  assign fault       = (state == FAULT);

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the five-stage pipeline: owns the program counter, drives the instruction ROM address, and loads the IF/ID pipeline register. It applies stall and branch-redirect requests from the hazard unit and EX stage, detects the halt word, and traps misaligned or out-of-range fetches. It also keeps saturating fetch and flush counters for bench statistics.

## Interface
- ROM_LAST_ADDR, 400: highest valid ROM byte address; a fetch is legal only if pc+3 <= ROM_LAST_ADDR.
- HALT_WORD, 32'hA800FFFF: jump-to-self encoding (opcode 101010, rs=rt=0, imm=-1) that ends the program.
- Ports (reset reset, synchronous, active-high; clock clock):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- branch_taken  in  1  EX stage: redirect fetch
- branch_target  in  32  byte address of redirect
- rom_instruction  in  32  combinational ROM read data for rom_address
- rom_address  out  32  equals pc
- if_id_instruction  out  32  latched instruction (0 = NOP)
- if_id_pc_plus4  out  32  pc+4 of latched instruction
- if_id_valid  out  1  IF/ID holds a real fetched instruction
- halted  out  1  state == HALT
- fault  out  1  state == FAULT
- fetch_count  out  16  saturating count of instructions latched
- flush_count  out  16  saturating count of branch redirects taken

## Operation
- States: RUN, HALT, FAULT. Reset -> RUN, pc=0, all outputs 0.
- Legal(pc) = pc[1:0]==0 and pc+3 <= ROM_LAST_ADDR.
- Per rising edge, priority order: reset > FAULT hold > branch_taken > stall > normal fetch.
- branch_taken (RUN or HALT): IF/ID flushed (instruction=0, pc_plus4=0, valid=0); flush_count+1; if branch_target legal, pc <= branch_target and state -> RUN, else state -> FAULT and pc is unchanged. Overrides stall on the same edge.
- stall (RUN, no branch): pc, IF/ID, and counters hold.
- Normal fetch (RUN): if pc is illegal, state -> FAULT and IF/ID is flushed. Otherwise IF/ID <= {rom_instruction, pc+4, valid=1}, fetch_count+1, and pc <= pc+4. If rom_instruction == HALT_WORD, the word is still latched, pc holds, and state -> HALT.
- HALT: pc holds; on the next non-stalled edge IF/ID is replaced with a bubble (valid=0); no further fetches. Only branch_taken (wrong-path halt) or reset leaves HALT.
- FAULT: sticky until reset. pc holds; IF/ID is a bubble; branch_taken is ignored and the counters freeze.
- Counters: 16-bit, saturate at 16'hFFFF with no wrap.
- Arithmetic: pc+4 wraps modulo 2^32 but is caught by the legality check. No sign handling: branch_target is already a resolved byte address.

## Timing
- rom_address = pc combinationally, so ROM data is sampled at the same edge: 1-cycle fetch latency from pc to IF/ID.
- Redirect: branch_taken seen at edge N; the target instruction is in IF/ID after edge N+1. One bubble on top of whatever the upstream stages discard.
- Stall asserted for k cycles delays IF/ID by exactly k cycles; no instruction is lost or duplicated.
- halted/fault rise in the cycle after the triggering edge (registered state).
- Reset asserted mid-run: at the next edge all state returns to reset values regardless of other inputs. The first fetch of address 0 occurs on the first edge with reset low.

## Test plan
- Straight-line fetch: ROM words 0..3 nonzero, no stall -> rom_address 0,4,8,12 on consecutive cycles; if_id_pc_plus4 4,8,12,16; fetch_count=4.
- Stall: stall high 3 cycles while pc=8 -> pc stays 8, IF/ID holds the word from address 4, fetch_count is unchanged; fetch resumes at 8.
- Redirect with stall: branch_taken=1, stall=1, branch_target=280 -> next cycle pc=280, if_id_valid=0, flush_count=1; the word at 280 is latched one edge later.
- Halt: HALT_WORD at address 360 -> latched with if_id_pc_plus4=364, halted=1, pc stays 360. A following branch_taken to 48 returns to RUN at pc=48.
- Fault: branch_target=0x66 (misaligned) -> fault=1, IF/ID bubble, later branch_taken ignored; likewise pc reaching 400 faults (400+3 > 400).
- Reset mid-run with pc=100 and fetch_count=20 -> after one reset edge, pc=0, counters 0, state RUN, if_id_valid=0.
